// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the
// byte-addressable data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEF_BASE_ADDR =
    32'h1001_0000;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

endpackage

// File: rtl/dmem_lane_steer.sv
// dmem_lane_steer: big-endian lane enables,
// store replication, load extract/extend, checks.
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ofs,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  rb;
  logic [15:0] rh;

  // be[i] enables bits [8i+7:8i]; offset 0 is the MSB lane
  always_comb begin
    be       = 4'b0000;
    wword    = wdata;
    misalign = 1'b0;
    illegal  = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        be    = 4'b1000 >> ofs;
        wword = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be       = ofs[1] ? 4'b0011 : 4'b1100;
        wword    = {2{wdata[15:0]}};
        misalign = ofs[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        misalign = |ofs;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    rb   = rword[{~ofs, 3'b000} +: 8];
    rh   = ofs[1] ? rword[15:0] : rword[31:16];
    rext = rword;
    unique case (size)
      SZ_BYTE: rext = {{24{sign_ext & rb[7]}}, rb};
      SZ_HALF: rext = {{16{sign_ext & rh[15]}}, rh};
      default: rext = rword;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: byte/half/word data memory with
// range/alignment faults and post-reset clear.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault,
  output logic        busy
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int IW    = AW - 2;
  localparam int WORDS = DEPTH_BYTES / 4;

  logic [31:0] mem [WORDS];

  state_t        state, state_n;
  logic [IW-1:0] cidx, cidx_n;

  logic [31:0]   off;
  logic          in_rng;
  logic [IW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wword, rext;
  logic          misalign, illegal;
  logic          acc, flt;

  logic          mem_wr;
  logic [IW-1:0] widx;
  logic [3:0]    wbe;
  logic [31:0]   wd;

  assign off    = addr - BASE_ADDR;
  assign in_rng = off < 32'(DEPTH_BYTES);
  assign idx    = off[AW-1:2];

  dmem_lane_steer u_steer (
    .size     (size),
    .ofs      (addr[1:0]),
    .sign_ext (sign_ext),
    .wdata    (wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wword    (wword),
    .rext     (rext),
    .misalign (misalign),
    .illegal  (illegal)
  );

  assign ready = (state == IDLE);
  assign busy  = (state == CLEAR);
  assign acc   = req & ready;
  assign flt   = misalign | illegal | ~in_rng;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      cidx  <= '0;
    end else begin
      state <= state_n;
      cidx  <= cidx_n;
    end
  end

  always_comb begin
    state_n = state;
    cidx_n  = cidx;
    unique case (state)
      CLEAR: begin
        cidx_n = cidx + 1'b1;
        if (cidx == IW'(WORDS - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // clear and stores share the single write port
  always_comb begin
    mem_wr = 1'b0;
    widx   = idx;
    wbe    = be;
    wd     = wword;
    if (busy) begin
      mem_wr = rst;
      widx   = cidx;
      wbe    = 4'b1111;
      wd     = '0;
    end else if (acc && we && !flt) begin
      mem_wr = rst;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      fault  <= 1'b0;
    end else begin
      rvalid <= acc & ~we;
      fault  <= acc & flt;
      if (acc && !we) rdata <= flt ? '0 : rext;
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: directed vectors for clear,
// sized loads/stores, faults and mid-clear reset.
module tb_dmem_sized;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        fault;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;
  int n;

  localparam logic [31:0] B = 32'h1001_0000;

  dmem_sized dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .fault    (fault),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(logic w, logic [1:0] sz,
                    logic sx, logic [31:0] a,
                    logic [31:0] d);
    req      = 1'b1;
    we       = w;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = d;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic ld_chk(string tag, logic [1:0] sz,
                        logic sx, logic [31:0] a,
                        logic [31:0] exp);
    op(1'b0, sz, sx, a, 32'h0);
    chk({tag, ".rdata"}, rdata, exp);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
  endtask

  task automatic flt_chk(string tag, logic w,
                         logic [1:0] sz,
                         logic [31:0] a);
    op(w, sz, 1'b0, a, 32'hAAAA_AAAA);
    chk({tag, ".fault"}, 32'(fault), 32'd1);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(!w));
    if (!w) chk({tag, ".rdata"}, rdata, 32'h0);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0;
    size = SZ_WORD; sign_ext = 1'b0;
    addr = B; wdata = '0;
    repeat (3) tick();
    chk("rst.ready",  32'(ready),  32'd0);
    chk("rst.busy",   32'(busy),   32'd1);
    chk("rst.rdata",  rdata,       32'h0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.fault",  32'(fault),  32'd0);

    rst = 1'b1;
    wait_ready(n);
    chk("clear.cycles", 32'(n), 32'd256);
    chk("clear.busy", 32'(busy), 32'd0);

    ld_chk("lw_top", SZ_WORD, 1'b0, B + 32'h3FC, 32'h0);

    op(1'b1, SZ_WORD, 1'b0, B + 32'h10, 32'hDEAD_BEEF);
    chk("sw.rvalid", 32'(rvalid), 32'd0);
    chk("sw.fault",  32'(fault),  32'd0);
    ld_chk("lw10", SZ_WORD, 1'b1, B + 32'h10,
           32'hDEAD_BEEF);
    ld_chk("lb10",  SZ_BYTE, 1'b1, B + 32'h10,
           32'hFFFF_FFDE);
    ld_chk("lbu13", SZ_BYTE, 1'b0, B + 32'h13,
           32'h0000_00EF);
    ld_chk("lh12",  SZ_HALF, 1'b1, B + 32'h12,
           32'hFFFF_BEEF);
    ld_chk("lhu10", SZ_HALF, 1'b0, B + 32'h10,
           32'h0000_DEAD);
    ld_chk("lb11",  SZ_BYTE, 1'b1, B + 32'h11,
           32'hFFFF_FFAD);

    op(1'b1, SZ_BYTE, 1'b0, B + 32'h11, 32'h1234_5611);
    ld_chk("sb_lw", SZ_WORD, 1'b0, B + 32'h10,
           32'hDE11_BEEF);
    op(1'b1, SZ_HALF, 1'b0, B + 32'h12, 32'hFFFF_1234);
    ld_chk("sh_lw", SZ_WORD, 1'b0, B + 32'h10,
           32'hDE11_1234);

    flt_chk("lw_mis", 1'b0, SZ_WORD, B + 32'h2);
    tick();
    chk("idle.rvalid", 32'(rvalid), 32'd0);
    chk("idle.fault",  32'(fault),  32'd0);
    flt_chk("sh_mis", 1'b1, SZ_HALF, B + 32'h11);
    ld_chk("sh_mis_mem", SZ_WORD, 1'b0, B + 32'h10,
           32'hDE11_1234);
    flt_chk("lw_oor", 1'b0, SZ_WORD, B + 32'h400);
    flt_chk("lw_low", 1'b0, SZ_WORD, B - 32'h4);
    flt_chk("sz11", 1'b0, 2'b11, B + 32'h10);
    flt_chk("sw_oor", 1'b1, SZ_WORD, B + 32'h400);
    ld_chk("lw_3fc", SZ_WORD, 1'b0, B + 32'h3FC, 32'h0);

    op(1'b1, SZ_WORD, 1'b0, B + 32'h20, 32'hCAFE_F00D);
    ld_chk("lw20", SZ_WORD, 1'b0, B + 32'h20,
           32'hCAFE_F00D);

    rst = 1'b0;
    tick();
    chk("rst2.ready", 32'(ready), 32'd0);
    rst = 1'b1;
    req = 1'b1; we = 1'b0; addr = B + 32'h20;
    repeat (100) tick();
    chk("clr.ign_rvalid", 32'(rvalid), 32'd0);
    chk("clr.ign_fault",  32'(fault),  32'd0);
    chk("clr.busy100",    32'(busy),   32'd1);
    req = 1'b0;
    rst = 1'b0;
    #2;
    chk("rst3.busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    wait_ready(n);
    chk("reclear.cycles", 32'(n), 32'd256);
    ld_chk("lw20_cleared", SZ_WORD, 1'b0, B + 32'h20,
           32'h0);
    ld_chk("lw10_cleared", SZ_WORD, 1'b0, B + 32'h10,
           32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised byte-addressable data memory for the single-cycle/multicycle MIPS datapath, successor to the fixed word-only data memory. It supports byte, halfword and word loads/stores with sign/zero extension, a configurable depth and data-segment base, alignment and range checking, and a hardware clear sequence after reset. It sits between the ALU address output and the write-back mux, behind a simple req/ready handshake.

## Interface
- DEPTH_BYTES, 1024: storage size in bytes; power of two, multiple of 4, at least 8.
- BASE_ADDR, 32'h1001_0000: first byte address of the data segment.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and faults.
- sign_ext  in  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte/half/word is used.
- ready  out  1  accepting requests.
- rdata  out  32  load result, registered.
- rvalid  out  1  one-cycle pulse: rdata is valid.
- fault  out  1  one-cycle pulse: last accepted request was misaligned, out of range or illegal size.
- busy  out  1  clear sequence in progress.

## Operation
- Byte order is big-endian: byte at offset o holds bits [31:24] of the word at o; o+3 holds [7:0].
- Offset = addr - BASE_ADDR in 32-bit arithmetic. In range iff offset < DEPTH_BYTES. No modulo wrap.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
- States: CLEAR, IDLE.
  - CLEAR: entered on reset. Writes zero to one word per cycle, word index 0 to DEPTH_BYTES/4-1. ready=0, busy=1. Moves to IDLE after the last word.
  - IDLE: ready=1, busy=0. A request is accepted when req && ready.
- Accepted store with no fault: writes only the addressed byte lanes at that edge. sb writes wdata[7:0]; sh writes wdata[15:0] with the high byte at the lower address.
- Accepted load with no fault: rdata is updated at that edge, and rvalid=1 for the following cycle.
  - Bytes and halves are right-justified, then extended according to sign_ext.
  - For a word load, sign_ext is ignored.
- Faulting request:
  - No memory write.
  - fault=1 for the following cycle.
  - A faulting load also sets rdata=0 and rvalid=1, so the pipeline never stalls on a response.
- Requests while ready=0 are ignored and produce no response.
- Reset values: ready=0, rdata=0, rvalid=0, fault=0, busy=1, state=CLEAR, clear index=0. These apply asynchronously while rst=0.

## Timing
- Load latency is 1 cycle. A request accepted at edge N gives rdata, rvalid and fault valid from N until N+1.
- One request per cycle, back-to-back, with no bubbles.
- Store at edge N followed by a load of the same address at edge N+1 returns the new data. There is no read-during-write hazard across cycles.
- Clear takes exactly DEPTH_BYTES/4 cycles after rst deasserts. ready rises at the edge that retires the last clear write.
- If rst asserts mid-clear or mid-access, the in-flight access is discarded, the outputs return to reset values, and the clear restarts from index 0.
- rvalid and fault never assert in CLEAR.

## Structure
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum {CLEAR, IDLE};
  - default BASE_ADDR constant.
- Storage is an array of DEPTH_BYTES/4 words with 4 byte-write-enables. The word index is offset[log2(DEPTH_BYTES)-1:2].
- One combinational sub-module, dmem_lane_steer, handles:
  - store-side lane enables and data replication from size and addr[1:0];
  - load-side byte/half extraction and extension;
  - the misalign/illegal-size flags.

## Test plan
- Reset then idle: rst low 3 cycles, then high. busy=1 and ready=0 for exactly 256 cycles (DEPTH_BYTES=1024), then ready=1. A lw from 0x1001_03FC returns 0.
- Word round trip: sw 0xDEADBEEF at 0x1001_0010, then lw 0x1001_0010 on the next cycle. rdata=0xDEADBEEF with rvalid=1 one cycle after acceptance.
- Sub-word:
  - After the store above, lb 0x1001_0010 → 0xFFFF_FFDE; lbu 0x1001_0013 → 0x0000_00EF; lh 0x1001_0012 → 0xFFFF_BEEF.
  - Then sb 0x11 at 0x1001_0011 and lw 0x1001_0010 → 0xDE11_BEEF.
- Faults:
  - lw at 0x1001_0002 → fault=1, rvalid=1, rdata=0.
  - sh at 0x1001_0005 → fault=1 and memory unchanged.
  - lw at 0x1001_0400 → fault=1 (out of range).
  - size=11 → fault=1.
- Reset mid-clear: assert rst at clear cycle 100. The index restarts, and ready rises 256 cycles after the second deassertion. A word written before the reset reads back as 0.
